// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter to 8-digit packed BCD with overflow glyph
module bin2bcd_seq #(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [31:0]      bcd_out
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t st, nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [35:0] work, adj;
  logic [CW-1:0] cnt;
  logic of9;
  always_comb nxt = st == IDLE ? (start ? SHIFT : IDLE) : st == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  always_comb begin
    adj = work;
    for (int i = 0; i < 9; i++) adj[4*i+:4] = work[4*i+:4] >= 4'd5 ? work[4*i+:4] + 4'd3 : work[4*i+:4];
  end
  assign of9 = |work[35:32];
  assign busy = st != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else st <= nxt;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bin_sh  <= '0;
      work    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= st == DONE;
      if (st == IDLE && start) begin
        bin_sh <= bin_in;
        work   <= '0;
        cnt    <= CW'(BIN_W);
      end
      if (st == SHIFT) begin
        work   <= 36'({adj, bin_sh[BIN_W-1]});
        bin_sh <= bin_sh << 1;
        cnt    <= cnt - 1'b1;
      end
      if (st == DONE) begin
        ovf     <= of9;
        bcd_out <= of9 ? 32'hEEEEEEEE : work[31:0];
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table vectors, handshake corner cases and random values against a decimal model
module tb_bin2bcd_seq;
  logic        clk = 0;
  logic        rstn, start, busy, done, ovf;
  logic [26:0] bin_in;
  logic [31:0] bcd_out;
  int total = 0, bad = 0;

  bin2bcd_seq #(.BIN_W(27)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] v;
    logic [31:0] b;
    logic        o;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [32:0] model(input logic [26:0] v);
    int unsigned x = v;
    logic [31:0] r = '0;
    if (x > 99999999) return {1'b1, 32'hEEEEEEEE};
    for (int k = 0; k < 8; k++) begin
      r[4*k+:4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  task automatic conv(input logic [26:0] v, output logic [31:0] b, output logic o, output int lat, output int bz);
    bin_in = v;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    lat = 0;
    bz = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bz++;
    end
    b = bcd_out;
    o = ovf;
  endtask

  vec_t tbl[7];
  logic [31:0] b, b1, b2;
  logic o;
  int lat, bz, nd, n, d1, d2;
  logic [26:0] rv;

  initial begin
    tbl[0] = '{27'd12345678, 32'h12345678, 1'b0};
    tbl[1] = '{27'd0,        32'h00000000, 1'b0};
    tbl[2] = '{27'd99999999, 32'h99999999, 1'b0};
    tbl[3] = '{27'd100000000, 32'hEEEEEEEE, 1'b1};
    tbl[4] = '{27'd134217727, 32'hEEEEEEEE, 1'b1};
    tbl[5] = '{27'd9,        32'h00000009, 1'b0};
    tbl[6] = '{27'd42,       32'h00000042, 1'b0};
    rstn = 0; start = 0; bin_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_bcd", 64'(bcd_out), 64'h0);
    chk("rst_flags", {busy, done, ovf}, 3'b000);
    rstn = 1;
    nd = 0;
    repeat (10) begin @(posedge clk); #1; if (done) nd++; end
    chk("idle_no_done", nd, 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      conv(tbl[i].v, b, o, lat, bz);
      chk($sformatf("tbl%0d_bcd", i), b, tbl[i].b);
      chk($sformatf("tbl%0d_ovf", i), o, tbl[i].o);
      chk($sformatf("tbl%0d_lat", i), lat, 28);
      if (i == 0) chk("busy_cycles", bz, 28);
      chk($sformatf("tbl%0d_busy_at_done", i), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_fall", i), done, 0);
    end

    // start pulse with a new value at step 10 must be ignored
    bin_in = 27'd555; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk); #1;
    bin_in = 27'd777; start = 1;
    @(posedge clk); #1;
    start = 0;
    nd = 0; b = '0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!done) chk("no_tear", bcd_out, nd == 0 ? 32'h00000042 : 32'h00000555);
      if (done) begin nd++; b = bcd_out; end
    end
    chk("ign_ndone", nd, 1);
    chk("ign_bcd", b, 32'h00000555);

    conv(27'd134217727, b, o, lat, bz);
    chk("pre_rst_ovf", o, 1);
    // reset mid-SHIFT must clear everything immediately
    bin_in = 27'd87654321; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk); #1;
    rstn = 0;
    #1;
    chk("mid_rst_bcd", 64'(bcd_out), 64'h0);
    chk("mid_rst_flags", {busy, done, ovf}, 3'b000);
    repeat (2) @(posedge clk); #1;
    rstn = 1;
    nd = 0;
    repeat (30) begin @(posedge clk); #1; if (done || busy) nd++; end
    chk("aborted_quiet", nd, 0);
    conv(27'd2024, b, o, lat, bz);
    chk("post_rst_bcd", b, 32'h00002024);
    chk("post_rst_lat", lat, 28);

    // start held high: back-to-back conversions
    bin_in = 27'd31; start = 1;
    @(posedge clk); #1;
    bin_in = 27'd32;
    n = 0; d1 = -1; d2 = -1; b1 = '0; b2 = '0;
    while (d2 < 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        if (d1 < 0) begin d1 = n; b1 = bcd_out; end
        else begin d2 = n; b2 = bcd_out; start = 0; end
      end
    end
    start = 0;
    chk("b2b_first_lat", d1, 28);
    chk("b2b_gap", d2 - d1, 29);
    chk("b2b_bcd1", b1, 32'h00000031);
    chk("b2b_bcd2", b2, 32'h00000032);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      rv = (i % 4 == 0) ? 27'(32'd99999990 + $urandom_range(0, 20)) : 27'($urandom);
      conv(rv, b, o, lat, bz);
      chk($sformatf("rand_%0d", rv), {o, b}, model(rv));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that produces the 32-bit, 8-digit packed-BCD word for the 8-digit seven-segment scan driver in character mode. Each nibble of the output drives one digit, with the least-significant nibble on AN0. The conversion uses shift-add-3 (double dabble), one bit per clock, behind a start/busy/done handshake. Values above 99,999,999 are flagged as overflow and displayed as "EEEEEEEE".

## Interface
- BIN_W, default 27: width of the binary input. Legal range is 1..27.
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  request a conversion of bin_in. Sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary value. Sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
- done  output  1  single-cycle pulse. bcd_out and ovf are valid and updated in this cycle.
- ovf  output  1  last result exceeded 99,999,999. Held until the next done.
- bcd_out  output  32  packed BCD; digit k is in bits [4k+3:4k]. Held until the next done.

## Operation
- Internal registers:
  - bin_sh, BIN_W bits: latched input, shifted left each step.
  - work, 36 bits: nine BCD digits. The ninth digit exists for overflow detection only.
  - cnt: step counter, wide enough to hold BIN_W.
- States and transitions:
  - IDLE: when start=1, latch bin_sh<=bin_in, clear work, set cnt<=BIN_W, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: perform one step per cycle and decrement cnt. The step that brings cnt to 0 is the last; the next state is DONE.
  - DONE: update outputs, pulse done, return to IDLE.
- Step definition, all in one cycle:
  - Every work nibble with value >= 5 gets +3. This is a 4-bit add with no carry into the next nibble; the corrected value is always <= 12.
  - Then work<={work[34:0], bin_sh[BIN_W-1]} and bin_sh<=bin_sh<<1.
- Result rules, applied in DONE:
  - ovf<=(work[35:32]!=0).
  - bcd_out<= ovf ? 32'hEEEEEEEE : work[31:0].
  - Digit E is the display's error glyph in character mode.
- start while busy is ignored: no queueing, no restart, and bin_in changes have no effect.
- No leading-zero blanking: 42 converts to 32'h00000042.

## Timing
- Reset values: busy=0, done=0, ovf=0, bcd_out=32'h00000000, state IDLE. The display shows "00000000" out of reset.
- rstn assertion at any point, including mid-SHIFT, aborts the conversion immediately and restores all reset values. No done is produced for the aborted request.
- Cycle sequence, with start accepted at edge E0:
  - busy=1 after E0.
  - Steps occur at E1..E_BIN_W.
  - At E_(BIN_W+1): done=1, busy=0, and bcd_out/ovf are updated, all together.
  - done falls after E_(BIN_W+2).
- Latency from start to done is BIN_W+1 clocks (28 for the default).
- A start held high during the done cycle is accepted at E_(BIN_W+2), because the block is in IDLE. Maximum throughput is one conversion per BIN_W+2 clocks.
- bcd_out never changes except in the done cycle or on reset. The scan driver may sample it at any time without tearing.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset then idle: after rstn rises, bcd_out=32'h00000000, ovf=0, busy=0, done=0. No done appears without start.
- Basic conversion:
  - bin_in=12345678, one-cycle start → done exactly 28 clocks later, bcd_out=32'h12345678, ovf=0, busy high for exactly 28 cycles.
  - bin_in=0 → 32'h00000000.
- Boundaries:
  - 99,999,999 → 32'h99999999 with ovf=0.
  - 100,000,000 → 32'hEEEEEEEE with ovf=1.
  - 134,217,727 (2^27-1) → 32'hEEEEEEEE with ovf=1.
  - 9 → 32'h00000009.
- Ignored start: launch 555, pulse start with bin_in=777 at step 10 → result 32'h00000555, and exactly one done.
- Reset mid-conversion: launch 87654321, drop rstn at step 14 → all outputs at reset values immediately. After release, converting 2024 → 32'h00002024.
- Back-to-back: start held high continuously with bin_in=31, then 32 → done pulses 29 clocks apart, results 32'h00000031 then 32'h00000032. Outputs checked against a software model over 1000 random 27-bit values.
